// File: rtl/mul16_sequencer.sv
// mul16_sequencer: unsigned 16x16 -> 32-bit multiply built from the shared
// ARU 8x8 multiplier and 16-bit adder. Four partial products are formed one
// per cycle. Four carry-propagating adds then combine them into the product.
module mul16_sequencer #(
  parameter int OPW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               start,
  input  logic [OPW-1:0]     op_a,
  input  logic [OPW-1:0]     op_b,
  output logic               busy,
  output logic               done,
  output logic [2*OPW-1:0]   result,
  output logic               aru_own,
  output logic [OPW-1:0]     aru_in0,
  output logic [OPW-1:0]     aru_in1,
  output logic               aru_add,
  output logic               aru_mul,
  input  logic [OPW-1:0]     aru_out,
  input  logic               aru_c
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_AMID, S_ALO, S_AHI, S_AHC, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [OPW-1:0] a, b;
  logic [OPW-1:0] pp0, pp1, pp2, pp3;
  logic [OPW-1:0] mid, lo, hi_tmp;
  logic           c1, c2;

  logic [7:0] al, ah, bl, bh;
  assign al = a[7:0];
  assign ah = a[15:8];
  assign bl = b[7:0];
  assign bh = b[15:8];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and ARU control decode from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    aru_in0   = '0;
    aru_in1   = '0;
    aru_add   = 1'b0;
    aru_mul   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_M0;
      S_M0: begin
        busy = 1'b1; aru_mul = 1'b1;
        aru_in0 = {8'h00, al}; aru_in1 = {8'h00, bl};
        state_nxt = S_M1;
      end
      S_M1: begin
        busy = 1'b1; aru_mul = 1'b1;
        aru_in0 = {8'h00, ah}; aru_in1 = {8'h00, bl};
        state_nxt = S_M2;
      end
      S_M2: begin
        busy = 1'b1; aru_mul = 1'b1;
        aru_in0 = {8'h00, al}; aru_in1 = {8'h00, bh};
        state_nxt = S_M3;
      end
      S_M3: begin
        busy = 1'b1; aru_mul = 1'b1;
        aru_in0 = {8'h00, ah}; aru_in1 = {8'h00, bh};
        state_nxt = S_AMID;
      end
      S_AMID: begin
        busy = 1'b1; aru_add = 1'b1;
        aru_in0 = pp1; aru_in1 = pp2;
        state_nxt = S_ALO;
      end
      S_ALO: begin
        busy = 1'b1; aru_add = 1'b1;
        aru_in0 = pp0; aru_in1 = {mid[7:0], 8'h00};
        state_nxt = S_AHI;
      end
      S_AHI: begin
        busy = 1'b1; aru_add = 1'b1;
        aru_in0 = pp3; aru_in1 = {7'h00, c1, mid[15:8]};
        state_nxt = S_AHC;
      end
      S_AHC: begin
        busy = 1'b1; aru_add = 1'b1;
        aru_in0 = hi_tmp; aru_in1 = {15'h0000, c2};
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including a start in IDLE.
    if (clr) state_nxt = S_IDLE;
  end

  assign aru_own = busy;

  // Operand latch, partial-product/sum capture and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0; b <= '0;
      pp0 <= '0; pp1 <= '0; pp2 <= '0; pp3 <= '0;
      mid <= '0; lo <= '0; hi_tmp <= '0;
      c1 <= 1'b0; c2 <= 1'b0;
      result <= '0;
    end else if (clr) begin
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a <= op_a;
          b <= op_b;
          result <= '0;
        end
        S_M0:   pp0 <= aru_out;
        S_M1:   pp1 <= aru_out;
        S_M2:   pp2 <= aru_out;
        S_M3:   pp3 <= aru_out;
        S_AMID: begin mid <= aru_out; c1 <= aru_c; end
        S_ALO:  begin lo  <= aru_out; c2 <= aru_c; end
        S_AHI:  hi_tmp <= aru_out;
        S_AHC:  result <= {aru_out, lo};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_sequencer.sv
// Self-checking bench for mul16_sequencer. A behavioural ARU answers the
// DUT's requests; products are checked against plain a*b arithmetic.
module tb_mul16_sequencer;

  logic        clk = 1'b0;
  logic        rst, clr, start;
  logic [15:0] op_a, op_b;
  logic        busy, done, aru_own, aru_add, aru_mul, aru_c;
  logic [31:0] result;
  logic [15:0] aru_in0, aru_in1, aru_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul16_sequencer #(.OPW(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .aru_own(aru_own), .aru_in0(aru_in0), .aru_in1(aru_in1),
    .aru_add(aru_add), .aru_mul(aru_mul),
    .aru_out(aru_out), .aru_c(aru_c)
  );

  // Behavioural ARU: 8x8 multiply of the low bytes, or 16-bit add with carry.
  logic [16:0] aru_sum;
  always_comb begin
    aru_sum = {1'b0, aru_in0} + {1'b0, aru_in1};
    aru_out = '0;
    aru_c   = 1'b0;
    if (aru_mul) aru_out = 16'(aru_in0[7:0]) * 16'(aru_in1[7:0]);
    else if (aru_add) begin
      aru_out = aru_sum[15:0];
      aru_c   = aru_sum[16];
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full multiply: checks per-cycle ARU control, latency, result and
  // the single-cycle done pulse. Operands are scrambled after acceptance.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string name);
    int n;
    bit ctl_ok;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    n = 1;
    ctl_ok = 1'b1;
    while (!done && n < 20) begin
      if (busy !== 1'b1 || aru_own !== 1'b1 ||
          aru_mul !== (n <= 4) || aru_add !== (n > 4))
        ctl_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check(ctl_ok, {name, " ctl"}, {28'h0, busy, aru_own, aru_mul, aru_add}, 32'h0);
    check(done === 1'b1, {name, " done_seen"}, 32'(done), 32'h1);
    check(n == 9, {name, " latency"}, 32'(n), 32'd9);
    check(result === exp, {name, " result"}, result, exp);
    check(busy === 1'b0 && aru_add === 1'b0 && aru_mul === 1'b0,
          {name, " done_ctl"}, {29'h0, busy, aru_add, aru_mul}, 32'h0);
    @(posedge clk); #1;
    check(done === 1'b0, {name, " pulse"}, 32'(done), 32'h0);
  endtask

  task automatic no_done(input int cycles, input string name);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check(!seen, name, 32'(seen), 32'h0);
  endtask

  initial begin
    int n, t;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, "basic"};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, "carry"};
    vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000, "zero"};
    vecs[3] = '{16'h0001, 16'hBEEF, 32'h0000BEEF, "one"};
    vecs[4] = '{16'h00FF, 16'h0100, 32'h0000FF00, "shift"};

    rst = 1'b1; clr = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    #12;
    check(busy === 1'b0 && done === 1'b0 && aru_own === 1'b0,
          "reset_flags", {29'h0, busy, done, aru_own}, 32'h0);
    check(result === 32'h0, "reset_result", result, 32'h0);
    check(aru_in0 === 16'h0 && aru_in1 === 16'h0 && aru_add === 1'b0 && aru_mul === 1'b0,
          "reset_aru", {aru_in0, aru_in1}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < 5; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Asynchronous reset mid-cycle clears a held result immediately.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check(result === 32'h0 && busy === 1'b0 && done === 1'b0,
          "async_rst_idle", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Start held high, operands changed mid-sequence; 10-cycle done period.
    @(negedge clk);
    op_a = 16'h00FF; op_b = 16'h0100; start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 20) begin
      if (n == 4) begin op_a = 16'h7777; op_b = 16'h7777; end
      @(posedge clk); #1;
      n++;
    end
    check(n == 9, "held_start latency", 32'(n), 32'd9);
    check(result === 32'h0000FF00, "held_start result", result, 32'h0000FF00);
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!done && t < 30);
    check(t == 10, "held_start period", 32'(t), 32'd10);
    check(result === 32'h7777 * 32'h7777, "held_start second", result, 32'h7777 * 32'h7777);
    start = 1'b0;
    @(posedge clk); #1;

    // Abort in ALO: back to IDLE, no done, result cleared; then normal run.
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1357; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check(busy === 1'b0 && done === 1'b0 && aru_own === 1'b0,
          "abort_idle", {29'h0, busy, done, aru_own}, 32'h0);
    check(result === 32'h0, "abort_result", result, 32'h0);
    no_done(12, "abort_no_done");
    do_op(16'hABCD, 16'h1357, 32'hABCD * 32'h1357, "after_abort");

    // Asynchronous reset during AHI.
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check(aru_add === 1'b1 && busy === 1'b1, "ahi_pre", {30'h0, aru_add, busy}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check(busy === 1'b0 && aru_add === 1'b0 && aru_own === 1'b0,
          "ahi_rst", {29'h0, busy, aru_add, aru_own}, 32'h0);
    @(negedge clk); rst = 1'b0;
    no_done(12, "ahi_rst_no_done");
    check(result === 32'h0, "ahi_rst_result", result, 32'h0);

    // Randomized products against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) ra = 16'hFFFF;
      if (i % 11 == 0) rb = 16'h0000;
      do_op(ra, rb, 32'(ra) * 32'(rb), "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul16_sequencer.md
Name: mul16_sequencer

Overview:
- Multi-cycle controller that computes an unsigned 16x16 -> 32-bit product using the shared 8x8 ARU multiplier and 16-bit ARU adder.
- Issues eight ARU operations in sequence: four 8x8 partial products, then four carry-propagating adds.
- Sits beside the ARU in the datapath. While busy, it owns the ARU operand muxes through aru_own. The main controller drives start and reads result on done.

Parameters:
- OPW, 16, operand width; fixed at 16, product width 2*OPW; other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous abort: return to IDLE, clear result
- start  input  1  request; sampled only in IDLE
- op_a  input  16  multiplicand, latched on accepted start
- op_b  input  16  multiplier, latched on accepted start
- busy  output  1  high while sequence in progress
- done  output  1  one-cycle pulse, result valid
- result  output  32  product, held until next accepted start/clr/rst
- aru_own  output  1  steer ARU operand muxes to this block (equals busy)
- aru_in0  output  16  ARU operand 0
- aru_in1  output  16  ARU operand 1
- aru_add  output  1  ARU ADD control
- aru_mul  output  1  ARU MUL control
- aru_out  input  16  ARU result (combinational, same cycle)
- aru_c  input  1  ARU carry out (valid with aru_add)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, aru_own=0, result=0; aru_in0/aru_in1=0; aru_add=aru_mul=0; internal regs (a, b, pp0..pp3, mid, c1, c2, lo) = 0.
- Naming: al/ah and bl/bh are the low/high bytes of the latched a and b.
- States, one per cycle, registered; aru_* are decoded from the current state:
  - IDLE: no ARU control asserted. If start=1 and clr=0: latch a=op_a, b=op_b, go to M0.
  - M0: in0={8'h0,al}, in1={8'h0,bl}, mul=1; pp0<=aru_out.
  - M1: in0={8'h0,ah}, in1={8'h0,bl}, mul=1; pp1<=aru_out.
  - M2: in0={8'h0,al}, in1={8'h0,bh}, mul=1; pp2<=aru_out.
  - M3: in0={8'h0,ah}, in1={8'h0,bh}, mul=1; pp3<=aru_out.
  - AMID: in0=pp1, in1=pp2, add=1; mid<=aru_out, c1<=aru_c.
  - ALO: in0=pp0, in1={mid[7:0],8'h00}, add=1; lo<=aru_out, c2<=aru_c.
  - AHI: in0=pp3, in1={7'h0,c1,mid[15:8]}, add=1; hi_tmp<=aru_out.
  - AHC: in0=hi_tmp, in1={15'h0,c2}, add=1; result<={aru_out,lo}; go to DONE.
  - DONE: done=1 for this cycle only; go to IDLE. start in DONE is ignored.
- busy=1 in states M0..AHC.
- Latency: start accepted at edge k -> busy high for cycles k+1..k+8 -> done high in cycle k+9. Back-to-back: next start is accepted at the edge that leaves IDLE, giving a minimum 10-cycle period.
- Exactly one of aru_add/aru_mul is high in each busy state; both are low in IDLE and DONE.
- The AHC add never overflows because the product fits in 32 bits; aru_c is ignored in AHI/AHC.
- start while busy or in DONE: ignored, no queuing. op_a/op_b changes while busy have no effect.
- clr=1 in any state: next state IDLE, result=0, done=0; clr has priority over start in the same cycle.
- rst mid-sequence: immediate return to reset values; the partial product is discarded.
- Operands of 0: full sequence still runs; result=0.

Test Plan:
- Reset: rst pulse mid-cycle -> busy=0, done=0, result=32'h0 asynchronously. Release, start=1, a=16'h1234, b=16'h5678 -> done exactly 9 cycles later, result=32'h06260060.
- Carry chain: a=16'hFFFF, b=16'hFFFF -> c1=1, c2=1 internally, result=32'hFFFE0001. Check aru_mul for 4 cycles, then aru_add for 4 cycles, aru_own=busy throughout.
- Zero/one: a=16'h0000, b=16'hBEEF -> result=0 after 9 cycles. a=16'h0001, b=16'hBEEF -> result=32'h0000BEEF.
- Ignored start: start held high continuously with a=16'h00FF, b=16'h0100 and operands changed to 16'h7777 mid-sequence -> first result=32'h0000FF00. Next accept occurs in the cycle after done; done period is 10 cycles.
- Abort: start, then clr=1 in state ALO -> IDLE next cycle, no done pulse, result=0. A new start then completes normally.
- Async reset during AHI: busy, aru_add and aru_own drop immediately; no done pulse follows.
